mdu_seq: RTL and testbench

Multi-cycle multiply/divide sequencer for the execute stage. It accepts the two operands produced by the operand-select stage (opnum1 = rs1 value, opnum2 = rs2 value) plus an M-extension opcode and runs a 64-iteration shift-add multiply or restoring divide. It returns the result over a valid/ready handshake and holds the pipeline stall line while it works. Only one operation is ever in flight.

---
 rtl/mdu_seq.sv | 144 ++++++++++++++
 tb/tb_mdu_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle shift-add multiply / restoring divide sequencer.
// Revision 1.0
`default_nettype none

module mdu_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_opnum1,
  input  logic [XLEN-1:0] in_opnum2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            is_div_q, is_rem_q, sgn_q, neg_quo_q, neg_rem_q;
  logic [XLEN-1:0] a_q, b_q, acc_q, res_q;

  // Request decode; reserved opcodes 5..7 fall through to MUL.
  logic            div_in, rem_in, sgn_in, a_neg, b_neg, div0_in, ovf_in;
  logic [XLEN-1:0] a_mag, b_mag;

  assign div_in  = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd3) || (in_op == 3'd4);
  assign rem_in  = (in_op == 3'd3) || (in_op == 3'd4);
  assign sgn_in  = (in_op == 3'd1) || (in_op == 3'd3);
  assign a_neg   = sgn_in && in_opnum1[XLEN-1];
  assign b_neg   = sgn_in && in_opnum2[XLEN-1];
  assign a_mag   = a_neg ? -in_opnum1 : in_opnum1;
  assign b_mag   = b_neg ? -in_opnum2 : in_opnum2;
  assign div0_in = div_in && (in_opnum2 == '0);
  assign ovf_in  = sgn_in && (in_opnum1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_opnum2 == '1);

  // One iteration of each datapath, plus the sign fix-up of the final result.
  logic [XLEN:0]   rem_sh;
  logic            rem_ge;
  logic [XLEN-1:0] rem_d, mul_acc_d, fix_res_d;

  assign rem_sh    = {acc_q, a_q[XLEN-1]};
  assign rem_ge    = rem_sh >= {1'b0, b_q};
  assign rem_d     = rem_ge ? (rem_sh[XLEN-1:0] - b_q) : rem_sh[XLEN-1:0];
  assign mul_acc_d = b_q[0] ? (acc_q + a_q) : acc_q;

  always_comb begin
    fix_res_d = acc_q;
    if (is_div_q) begin
      if (is_rem_q) fix_res_d = (sgn_q && neg_rem_q) ? -acc_q : acc_q;
      else          fix_res_d = (sgn_q && neg_quo_q) ? -a_q : a_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      is_rem_q  <= 1'b0;
      sgn_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      res_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && !kill) begin
            is_div_q  <= div_in;
            is_rem_q  <= rem_in;
            sgn_q     <= sgn_in;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            a_q       <= div_in ? a_mag : in_opnum1;
            b_q       <= div_in ? b_mag : in_opnum2;
            acc_q     <= '0;
            if (div0_in) begin
              res_q   <= rem_in ? in_opnum1 : '1;
              state_q <= DONE;
            end else if (ovf_in) begin
              res_q   <= rem_in ? '0 : in_opnum1;
              state_q <= DONE;
            end else begin
              cnt_q   <= CW'(XLEN-1);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (kill) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            if (is_div_q) begin
              acc_q <= rem_d;
              a_q   <= {a_q[XLEN-2:0], rem_ge};
            end else begin
              acc_q <= mul_acc_d;
              a_q   <= a_q << 1;
              b_q   <= b_q >> 1;
            end
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) state_q <= FIX;
          end
        end
        FIX: begin
          if (kill) begin
            state_q <= IDLE;
          end else begin
            res_q   <= fix_res_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          // result register is zeroed on exit so out_result reads 0 outside DONE
          if (kill || out_ready) begin
            res_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_result = res_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed self-checking bench for mdu_seq.
// Revision 1.0
`default_nettype none

module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [63:0] in_opnum1 = '0;
  logic [63:0] in_opnum2 = '0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mdu_seq #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_opnum1(in_opnum1), .in_opnum2(in_opnum2), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns with time #1 after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_opnum1 = a; in_opnum2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency counted in cycles after the accept cycle (1 = DONE right after accept).
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
    int lat;
    issue(op, a, b);
    chk({tag, "_busy_after_accept"}, busy, 1'b1);
    wait_valid(lat);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_result"}, out_result, exp);
    chk({tag, "_no_ready_in_done"}, in_ready, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_idle_after_handshake"}, {out_valid, in_ready, busy}, 3'b010);
  endtask

  initial begin
    int lat;
    logic [63:0] held;
    logic seen;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_state", {in_ready, out_valid, busy}, 3'b100);
    chk("reset_result", out_result, 64'd0);

    run_op("mul_7x6",   3'd0, 64'd7, 64'd6, 64'd42, 66);
    run_op("mul_ffx2",  3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    run_op("div_m7_2",  3'd1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    run_op("rem_m7_2",  3'd3, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    run_op("divu_100_7", 3'd2, 64'd100, 64'd7, 64'd14, 66);
    run_op("remu_100_7", 3'd4, 64'd100, 64'd7, 64'd2, 66);
    run_op("divu_by0",  3'd2, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("rem_by0",   3'd3, 64'd5, 64'd0, 64'd5, 1);
    run_op("div_ovf",   3'd1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf",   3'd3, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run_op("div_12_m5", 3'd1, 64'd12, -64'sd5, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    run_op("mul_rsvd7", 3'd7, 64'd11, 64'd13, 64'd143, 66);

    // Backpressure: DONE must hold for as long as out_ready stays low.
    out_ready = 1'b0;
    issue(3'd2, 64'd1000, 64'd9);
    wait_valid(lat);
    chk("bp_latency", lat, 66);
    held = out_result;
    chk("bp_result", held, 64'd111);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_flags", {out_valid, in_ready, busy}, 3'b101);
      chk("bp_hold_result", out_result, 64'd111);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {out_valid, in_ready, busy}, 3'b010);
    run_op("bp_next_op", 3'd0, 64'd5, 64'd5, 64'd25, 66);

    // Kill during CALC: no result delivered, then a normal op still works.
    issue(3'd0, 64'd123, 64'd456);
    repeat (19) @(posedge clk);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    chk("kill_idle", {out_valid, in_ready, busy}, 3'b010);
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    chk("kill_no_result", seen, 1'b0);
    run_op("mul_3x3_after_kill", 3'd0, 64'd3, 64'd3, 64'd9, 66);

    // Reset mid-CALC.
    issue(3'd1, 64'd77, 64'd7);
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("rst_mid_flags", {in_ready, out_valid, busy}, 3'b100);
    chk("rst_mid_result", out_result, 64'd0);
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (out_valid || busy) seen = 1'b1; end
    chk("rst_no_stale", seen, 1'b0);

    // kill in IDLE blocks acceptance of a simultaneous request.
    @(negedge clk);
    kill = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_opnum1 = 64'd2; in_opnum2 = 64'd2;
    @(posedge clk); #1;
    kill = 1'b0; in_valid = 1'b0;
    chk("idle_kill_no_accept", {in_ready, busy}, 2'b10);
    repeat (3) @(posedge clk); #1;
    chk("idle_kill_still_idle", {in_ready, out_valid, busy}, 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
